// File: rtl/sram_bus_arbiter.sv
// Two-into-one SRAM-like bus arbiter: inst and data slaves share one master port,
// data has priority unless a pending inst request has waited STARVE_LIMIT grants.
module sram_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  output logic [1:0]  owner,
  output logic        busy
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_INST = 2'b01;
  localparam logic [1:0] OWN_DATA = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'b00, ADDR = 2'b01, DATA = 2'b10} state_t;

  state_t        r_state, w_next;
  logic [1:0]    r_owner, w_grant;
  logic [CW-1:0] r_starve, w_starve_next;
  logic          r_wr;
  logic [1:0]    r_size;
  logic [31:0]   r_addr, r_wdata;
  logic          w_sel_req, w_sel_wr, w_addr_ok, w_data_ok, w_inst_win;
  logic [1:0]    w_sel_size;
  logic [31:0]   w_sel_addr, w_sel_wdata;

  assign inst_rdata = m_rdata;
  assign data_rdata = m_rdata;
  assign busy       = (r_state != IDLE);
  assign owner      = busy ? r_owner : OWN_NONE;

  // Arbitration and starvation counter update
  always_comb begin
    w_inst_win    = inst_req && (!data_req || (r_starve == CW'(STARVE_LIMIT)));
    w_grant       = OWN_NONE;
    w_starve_next = r_starve;
    if (w_inst_win) begin
      w_grant = OWN_INST;
    end else if (data_req) begin
      w_grant = OWN_DATA;
    end else begin
      w_grant = OWN_NONE;
    end
    if (r_state == IDLE) begin
      if (w_grant == OWN_INST || !inst_req) begin
        w_starve_next = '0;
      end else if (w_grant == OWN_DATA && r_starve != CW'(STARVE_LIMIT)) begin
        w_starve_next = r_starve + CW'(1);
      end else begin
        w_starve_next = r_starve;
      end
    end
  end

  // Mux of the current grant holder's request signals
  always_comb begin
    w_sel_req   = 1'b0;
    w_sel_wr    = 1'b0;
    w_sel_size  = 2'b00;
    w_sel_addr  = 32'h0000_0000;
    w_sel_wdata = 32'h0000_0000;
    case (r_owner)
      OWN_INST: begin
        w_sel_req = inst_req; w_sel_wr = inst_wr; w_sel_size = inst_size;
        w_sel_addr = inst_addr; w_sel_wdata = inst_wdata;
      end
      OWN_DATA: begin
        w_sel_req = data_req; w_sel_wr = data_wr; w_sel_size = data_size;
        w_sel_addr = data_addr; w_sel_wdata = data_wdata;
      end
      default: begin
        w_sel_req = 1'b0;
      end
    endcase
  end

  // Next state and master-side outputs; outside ADDR the latched request is shown
  always_comb begin
    w_next    = r_state;
    m_req     = 1'b0;
    m_wr      = r_wr;
    m_size    = r_size;
    m_addr    = r_addr;
    m_wdata   = r_wdata;
    w_addr_ok = 1'b0;
    w_data_ok = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant != OWN_NONE) w_next = ADDR;
        else                     w_next = IDLE;
      end
      ADDR: begin
        m_req   = w_sel_req;
        m_wr    = w_sel_wr;
        m_size  = w_sel_size;
        m_addr  = w_sel_addr;
        m_wdata = w_sel_wdata;
        if (!w_sel_req) begin
          w_next = IDLE;
        end else if (m_addr_ok) begin
          w_addr_ok = 1'b1;
          if (m_data_ok) begin
            w_data_ok = 1'b1;
            w_next    = IDLE;
          end else begin
            w_next = DATA;
          end
        end else begin
          w_next = ADDR;
        end
      end
      DATA: begin
        if (m_data_ok) begin
          w_data_ok = 1'b1;
          w_next    = IDLE;
        end else begin
          w_next = DATA;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign inst_addr_ok = w_addr_ok && (r_owner == OWN_INST);
  assign data_addr_ok = w_addr_ok && (r_owner == OWN_DATA);
  assign inst_data_ok = w_data_ok && (r_owner == OWN_INST);
  assign data_data_ok = w_data_ok && (r_owner == OWN_DATA);

  // State, grant, starvation counter and latched master request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_owner  <= OWN_NONE;
      r_starve <= '0;
      r_wr     <= 1'b0;
      r_size   <= 2'b00;
      r_addr   <= 32'h0000_0000;
      r_wdata  <= 32'h0000_0000;
    end else begin
      r_state  <= w_next;
      r_starve <= w_starve_next;
      if (r_state == IDLE && w_grant != OWN_NONE) r_owner <= w_grant;
      if (r_state == ADDR) begin
        r_wr    <= w_sel_wr;
        r_size  <= w_sel_size;
        r_addr  <= w_sel_addr;
        r_wdata <= w_sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed self-checking bench for sram_bus_arbiter.
module tb_sram_bus_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic inst_req = 1'b0, inst_wr = 1'b0; logic [1:0] inst_size = 2'b00;
  logic [31:0] inst_addr = 32'h0, inst_wdata = 32'h0, inst_rdata;
  logic inst_addr_ok, inst_data_ok;
  logic data_req = 1'b0, data_wr = 1'b0; logic [1:0] data_size = 2'b00;
  logic [31:0] data_addr = 32'h0, data_wdata = 32'h0, data_rdata;
  logic data_addr_ok, data_data_ok;
  logic m_req, m_wr; logic [1:0] m_size; logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'h0; logic m_addr_ok = 1'b0, m_data_ok = 1'b0;
  logic [1:0] owner; logic busy;
  int checks = 0, failures = 0;

  sram_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic test_reset();
    rst = 1'b0; inst_req = 1'b1; data_req = 1'b1; inst_addr = 32'hDEAD_BEEF; m_addr_ok = 1'b1; m_data_ok = 1'b1;
    tick(); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (owner !== 2'b00) begin failures++; $display("FAIL reset_owner: got %b expected 00", owner); end
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL reset_m_req: got %b expected 0", m_req); end
    checks++; if ({m_wr, m_size, m_addr, m_wdata} !== 67'h0) begin failures++; $display("FAIL reset_m_bus: got %h expected 0", {m_wr, m_size, m_addr, m_wdata}); end
    checks++; if ({inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok} !== 4'b0000) begin failures++; $display("FAIL reset_oks: got %b expected 0000", {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok}); end
    inst_req = 1'b0; data_req = 1'b0; inst_addr = 32'h0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick(); rst = 1'b1;
    tick();
  endtask

  task automatic test_inst_read();
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = 32'hBFC0_0000; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rd_c0_m_req: got %b expected 0", m_req); end
    tick(); #1;
    checks++; if (m_req !== 1'b1 || m_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rd_c1_addr: got req=%b addr=%h expected 1 bfc00000", m_req, m_addr); end
    checks++; if (owner !== 2'b01 || busy !== 1'b1) begin failures++; $display("FAIL rd_c1_owner: got %b busy=%b expected 01 1", owner, busy); end
    checks++; if (inst_addr_ok !== 1'b0) begin failures++; $display("FAIL rd_c1_addr_ok: got %b expected 0", inst_addr_ok); end
    tick(); m_addr_ok = 1'b1; #1;
    checks++; if (inst_addr_ok !== 1'b1 || data_addr_ok !== 1'b0 || m_req !== 1'b1) begin failures++; $display("FAIL rd_c2_addr_ok: got i=%b d=%b req=%b expected 1 0 1", inst_addr_ok, data_addr_ok, m_req); end
    tick(); m_addr_ok = 1'b0; inst_req = 1'b0; inst_addr = 32'h1234_5678; #1;
    checks++; if (m_req !== 1'b0 || busy !== 1'b1 || m_addr !== 32'hBFC0_0000) begin failures++; $display("FAIL rd_c3_data_wait: got req=%b busy=%b addr=%h expected 0 1 bfc00000", m_req, busy, m_addr); end
    checks++; if (inst_data_ok !== 1'b0) begin failures++; $display("FAIL rd_c3_data_ok: got %b expected 0", inst_data_ok); end
    tick(); m_data_ok = 1'b1; m_rdata = 32'h3C08_0001; #1;
    checks++; if (inst_data_ok !== 1'b1 || inst_rdata !== 32'h3C08_0001 || data_data_ok !== 1'b0) begin failures++; $display("FAIL rd_c4_data: got ok=%b rdata=%h dok=%b expected 1 3c080001 0", inst_data_ok, inst_rdata, data_data_ok); end
    checks++; if (data_rdata !== 32'h3C08_0001) begin failures++; $display("FAIL rd_c4_data_rdata: got %h expected 3c080001", data_rdata); end
    tick(); m_data_ok = 1'b0; #1;
    checks++; if (busy !== 1'b0 || owner !== 2'b00 || m_req !== 1'b0) begin failures++; $display("FAIL rd_c5_idle: got busy=%b owner=%b req=%b expected 0 00 0", busy, owner, m_req); end
    inst_addr = 32'h0;
  endtask

  task automatic test_simultaneous();
    m_addr_ok = 1'b1; m_data_ok = 1'b1;
    inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'b00; data_addr = 32'h8000_0003; data_wdata = 32'h0000_00AB; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL sim_c0_m_req: got %b expected 0", m_req); end
    tick(); #1;
    checks++; if (owner !== 2'b10 || m_wr !== 1'b1 || m_addr !== 32'h8000_0003 || m_size !== 2'b00) begin failures++; $display("FAIL sim_data_first: got owner=%b wr=%b addr=%h size=%b expected 10 1 80000003 00", owner, m_wr, m_addr, m_size); end
    checks++; if ({data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok} !== 4'b1100) begin failures++; $display("FAIL sim_data_oks: got %b expected 1100", {data_addr_ok, data_data_ok, inst_addr_ok, inst_data_ok}); end
    tick(); data_req = 1'b0; #1;
    checks++; if (busy !== 1'b0 || m_req !== 1'b0) begin failures++; $display("FAIL sim_idle_after_same_cycle: got busy=%b req=%b expected 0 0", busy, m_req); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin failures++; $display("FAIL sim_stray_data_ok: got %b expected 00", {inst_data_ok, data_data_ok}); end
    tick(); #1;
    checks++; if (owner !== 2'b01 || m_wr !== 1'b0 || m_addr !== 32'hBFC0_0004 || m_req !== 1'b1) begin failures++; $display("FAIL sim_inst_next: got owner=%b wr=%b addr=%h req=%b expected 01 0 bfc00004 1", owner, m_wr, m_addr, m_req); end
    checks++; if ({inst_addr_ok, inst_data_ok} !== 2'b11) begin failures++; $display("FAIL sim_inst_oks: got %b expected 11", {inst_addr_ok, inst_data_ok}); end
    tick(); inst_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; data_wr = 1'b0; #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sim_end_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_starvation();
    logic [1:0] exp_owner [6] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    m_addr_ok = 1'b1; m_data_ok = 1'b1; inst_req = 1'b1; data_req = 1'b1;
    for (int g = 0; g < 6; g++) begin
      tick(); #1;
      checks++; if (owner !== exp_owner[g]) begin failures++; $display("FAIL starve_grant%0d: got %b expected %b", g, owner, exp_owner[g]); end
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    inst_req = 1'b1; inst_addr = 32'hBFC0_0010;
    tick(); #1;
    checks++; if (m_req !== 1'b1 || owner !== 2'b01) begin failures++; $display("FAIL abort_addr: got req=%b owner=%b expected 1 01", m_req, owner); end
    inst_req = 1'b0; #1;
    checks++; if (m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin failures++; $display("FAIL abort_drop: got req=%b aok=%b expected 0 0", m_req, inst_addr_ok); end
    tick(); m_data_ok = 1'b1; #1;
    checks++; if (busy !== 1'b0 || m_req !== 1'b0 || inst_data_ok !== 1'b0) begin failures++; $display("FAIL abort_idle: got busy=%b req=%b dok=%b expected 0 0 0", busy, m_req, inst_data_ok); end
    tick(); m_data_ok = 1'b0;
  endtask

  task automatic test_reset_in_data();
    data_req = 1'b1; data_addr = 32'h8000_1000;
    tick(); m_addr_ok = 1'b1;
    tick(); m_addr_ok = 1'b0; data_req = 1'b0; #1;
    checks++; if (busy !== 1'b1 || owner !== 2'b10) begin failures++; $display("FAIL rstd_in_data: got busy=%b owner=%b expected 1 10", busy, owner); end
    rst = 1'b0; #1;
    checks++; if (busy !== 1'b0 || owner !== 2'b00 || m_addr !== 32'h0 || m_req !== 1'b0) begin failures++; $display("FAIL rstd_async: got busy=%b owner=%b addr=%h req=%b expected 0 00 0 0", busy, owner, m_addr, m_req); end
    tick(); rst = 1'b1;
    tick(); m_data_ok = 1'b1; #1;
    checks++; if ({inst_data_ok, data_data_ok, busy} !== 3'b000) begin failures++; $display("FAIL rstd_stray: got %b expected 000", {inst_data_ok, data_data_ok, busy}); end
    tick(); m_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h8000_2000; #1;
    checks++; if (m_req !== 1'b0) begin failures++; $display("FAIL rstd_req_idle: got %b expected 0", m_req); end
    tick(); #1;
    checks++; if (m_req !== 1'b1 || owner !== 2'b10 || m_addr !== 32'h8000_2000) begin failures++; $display("FAIL rstd_regrant: got req=%b owner=%b addr=%h expected 1 10 80002000", m_req, owner, m_addr); end
    m_addr_ok = 1'b1; m_data_ok = 1'b1; #1;
    checks++; if ({data_addr_ok, data_data_ok} !== 2'b11) begin failures++; $display("FAIL rstd_complete: got %b expected 11", {data_addr_ok, data_data_ok}); end
    tick(); data_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_simultaneous();
    test_starvation();
    test_abort();
    test_reset_in_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
